hazard_ctrl_pipe: RTL

//  Producer side of the hazard-control interface. Carries register addresses and control bits D->E->M->W.

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_ctrl_stage.sv | 26 ++
 rtl/hazard_ctrl_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard-control pipe: address width, PC register index, stage bundles.
// Latency: none (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  localparam int RA_W = 4;
  localparam logic [RA_W-1:0] PC_REG = RA_W'(15);

  // Control bundle carried from decode into execute.
  typedef struct packed {
    logic            regWrite;
    logic            memtoReg;
    logic            pcSrc;
    logic            branch;
    logic [RA_W-1:0] wa3;
  } ctrl_t;

  // Full D->E payload: control bundle plus both source addresses.
  typedef struct packed {
    ctrl_t           ctrl;
    logic [RA_W-1:0] ra1;
    logic [RA_W-1:0] ra2;
  } execReg_t;

  // After execute only the condition-qualified write bits and destination survive.
  typedef struct packed {
    logic            regWrite;
    logic            pcSrc;
    logic [RA_W-1:0] wa3;
  } wbReg_t;

  // Address compare; optionally ignores the PC register, whose reads never forward.
  function automatic logic addrMatch(input logic [RA_W-1:0] src,
                                     input logic [RA_W-1:0] dst,
                                     input logic            filterR15);
    return (src == dst) && !(filterR15 && (src == PC_REG));
  endfunction

endpackage

// File: rtl/hazard_ctrl_stage.sv
// Generic pipeline stage register with synchronous clear and load enable.
// Latency: 1 clock from d to q.
// Backpressure: en=0 holds the stage; clear (or reset) loads all-zero.
import hazard_pkg::*;

module hazard_ctrl_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Stage register: reset and clear both produce a bubble; clear beats enable.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Carries register addresses and control bits D->E->M->W and derives hazard-unit inputs.
// Latency: decode bits visible in E after 1 clock, M after 2, W after 3; compares are combinational.
// Backpressure: StallD holds decode validity, FlushD/FlushE squash; M/W never stall. Option: HAZARD_R15_FILTER_EN.
import hazard_pkg::*;

module hazard_ctrl_pipe (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] RA1D,
  input  logic [RA_W-1:0] RA2D,
  input  logic [RA_W-1:0] WA3D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            PCSrcD,
  input  logic            BranchD,
  input  logic            CondExE,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  output logic            Match_1E_M,
  output logic            Match_1E_W,
  output logic            Match_2E_M,
  output logic            Match_2E_W,
  output logic            Match_12D_E,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic            MemtoRegE,
  output logic            PCWrPendingF,
  output logic            BranchTakenE,
  output logic            PCSrcW
);

`ifdef HAZARD_R15_FILTER_EN
  localparam logic FilterR15 = 1'b1;
`else
  localparam logic FilterR15 = 1'b0;
`endif

  logic     validD;
  execReg_t execD;
  execReg_t execE;
  wbReg_t   memD;
  wbReg_t   memM;
  wbReg_t   wbW;

  // Decode validity: flush wins over stall, stall holds, otherwise the slot is live.
  always_ff @(posedge clk) begin
    if (reset) begin
      validD <= 1'b0;
    end else if (FlushD) begin
      validD <= 1'b0;
    end else if (!StallD) begin
      validD <= 1'b1;
    end
  end

  // Build the D->E payload; control bits are qualified by decode validity, addresses are raw.
  always_comb begin
    execD               = '0;
    execD.ctrl.regWrite = RegWriteD & validD;
    execD.ctrl.memtoReg = MemtoRegD & validD;
    execD.ctrl.pcSrc    = PCSrcD & validD;
    execD.ctrl.branch   = BranchD & validD;
    execD.ctrl.wa3      = WA3D;
    execD.ra1           = RA1D;
    execD.ra2           = RA2D;
  end

  // Execute stage is never stalled; FlushE alone inserts the bubble.
  hazard_ctrl_stage #(.W($bits(execReg_t))) stageE (
    .clk   (clk),
    .reset (reset),
    .clear (FlushE),
    .en    (1'b1),
    .d     (execD),
    .q     (execE)
  );

  // Writes that fail their condition are dropped on the way into memory stage.
  always_comb begin
    memD          = '0;
    memD.regWrite = execE.ctrl.regWrite & CondExE;
    memD.pcSrc    = execE.ctrl.pcSrc & CondExE;
    memD.wa3      = execE.ctrl.wa3;
  end

  hazard_ctrl_stage #(.W($bits(wbReg_t))) stageM (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (1'b1),
    .d     (memD),
    .q     (memM)
  );

  hazard_ctrl_stage #(.W($bits(wbReg_t))) stageW (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (1'b1),
    .d     (memM),
    .q     (wbW)
  );

  // Forwarding and load-use compares on registered addresses.
  always_comb begin
    Match_1E_M  = addrMatch(execE.ra1, memM.wa3, FilterR15);
    Match_1E_W  = addrMatch(execE.ra1, wbW.wa3, FilterR15);
    Match_2E_M  = addrMatch(execE.ra2, memM.wa3, FilterR15);
    Match_2E_W  = addrMatch(execE.ra2, wbW.wa3, FilterR15);
    Match_12D_E = addrMatch(RA1D, execE.ctrl.wa3, FilterR15) |
                  addrMatch(RA2D, execE.ctrl.wa3, FilterR15);
  end

  assign RegWriteM    = memM.regWrite;
  assign RegWriteW    = wbW.regWrite;
  assign MemtoRegE    = execE.ctrl.memtoReg;
  assign PCWrPendingF = (PCSrcD & validD) | execE.ctrl.pcSrc | memM.pcSrc;
  assign BranchTakenE = execE.ctrl.branch & CondExE;
  assign PCSrcW       = wbW.pcSrc;

endmodule
